branch_predictor: RTL

Bimodal branch predictor for the ID stage of the RV32I pipeline. Holds a table of 2-bit saturating counters indexed by PC. Each cycle it gives a taken/not-taken prediction and the branch target for the instruction in decode. The same counters are trained with the resolved outcome of the conditional branch currently in MEM. The `prediction` output travels down the pipeline as the `predicted` flag consumed by branch resolution. Resolution's `decision` and `mispredict` outputs return here to train the table and drive two performance counters.

---
 rtl/branch_predictor.sv | 75 +++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Bimodal predictor: 2-bit saturating counters indexed by PC, combinational prediction/target.
// Training and perf counters update one edge after a qualifying MEM branch; mem_stall freezes both.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         in_addr,
  input  logic [31:0]         offset,
  input  logic                branch_decode_sig,
  output logic [31:0]         branch_addr,
  output logic                prediction,
  input  logic [31:0]         mem_addr,
  input  logic                branch_mem_sig,
  input  logic                actual_branch_decision,
  input  logic                mispredict_in,
  input  logic                mem_stall,
  output logic [CNT_BITS-1:0] branch_count,
  output logic [CNT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [1:0]          ctr_table [ENTRIES];
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic                train;
  logic [1:0]          cur_ctr;
  logic [1:0]          nxt_ctr;
  logic                unused_mem_bits;

  assign rd_idx = in_addr[IDX_BITS+1:2];
  assign wr_idx = mem_addr[IDX_BITS+1:2];
  assign unused_mem_bits = ^{mem_addr[31:IDX_BITS+2], mem_addr[1:0]};

  assign train = branch_mem_sig & ~mem_stall;

  // Reads come straight from the flops, so a same-index write is seen only next cycle.
  assign prediction  = branch_decode_sig & ctr_table[rd_idx][1];
  assign branch_addr = in_addr + offset;

  assign cur_ctr = ctr_table[wr_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (actual_branch_decision) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= 2'b01;
    end else if (train) begin
      ctr_table[wr_idx] <= nxt_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      if (branch_count != CNT_MAX) branch_count <= branch_count + CNT_ONE;
      if (mispredict_in && (mispredict_count != CNT_MAX))
        mispredict_count <= mispredict_count + CNT_ONE;
    end
  end

endmodule
